// File: rtl/mm_block_reader.sv
// mm_block_reader: Avalon-MM pipelined read master that fetches a block of
// consecutive words into a show-ahead FIFO and streams them out (valid/ready).
// Ports: Clk, Reset (async, active-low); Start/Base_Address/Length request;
//   Busy/Done status; Avalon_* read master (ChipEnable, Address, ByteEnable,
//   Read, Write, WriteData, WaitRequest, ReadData, ReadDataValid);
//   Stream_Data/Stream_Valid/Stream_Ready output stream.
// Optional: define MM_READ_CHECKSUM_EN to add the Checksum output, a running
//   modulo-2^DATA_WIDTH sum of all words delivered on the stream.
module mm_block_reader #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 13,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_Address,
    input  logic [LEN_WIDTH-1:0]  Length,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Avalon_ChipEnable,
    output logic [ADDR_WIDTH-1:0] Avalon_Address,
    output logic [1:0]            Avalon_ByteEnable,
    output logic                  Avalon_Read,
    output logic                  Avalon_Write,
    output logic [DATA_WIDTH-1:0] Avalon_WriteData,
    input  logic                  Avalon_WaitRequest,
    input  logic [DATA_WIDTH-1:0] Avalon_ReadData,
    input  logic                  Avalon_ReadDataValid,
    output logic [DATA_WIDTH-1:0] Stream_Data,
    output logic                  Stream_Valid,
    input  logic                  Stream_Ready
`ifdef MM_READ_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] Checksum
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic                  read_q, read_d;
    logic [CW-1:0]         pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic        accept;
    logic        ret;
    logic        pop;
    logic [CW:0] credit;

    always_comb begin
        accept   = read_q && !Avalon_WaitRequest;
        // A return with nothing outstanding is stale and is dropped.
        ret      = Avalon_ReadDataValid && (pend_q != '0);
        pop      = (cnt_q != '0) && Stream_Ready;
        pend_d   = pend_q + CW'(accept) - CW'(ret);
        cnt_d    = cnt_q + CW'(ret) - CW'(pop);
        wptr_d   = wptr_q + PW'(ret);
        rptr_d   = rptr_q + PW'(pop);
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        if (accept) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            issued_d = issued_q + LEN_WIDTH'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    addr_d   = Base_Address;
                    len_d    = Length;
                    issued_d = '0;
                    state_d  = (Length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (accept && issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend_q == '0 && cnt_q == '0 && !Avalon_ReadDataValid) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outstanding reads plus buffered words must leave room for one more.
        credit = {1'b0, pend_d} + {1'b0, cnt_d};
        if (read_q && Avalon_WaitRequest) begin
            read_d = 1'b1;
        end else begin
            read_d = (state_d == READ) && (credit < DEPTH_C) &&
                     (issued_d < len_d);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            read_q   <= 1'b0;
            pend_q   <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            read_q   <= read_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge Clk) begin
        if (ret) begin
            mem_q[wptr_q] <= Avalon_ReadData;
        end
    end

`ifdef MM_READ_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && Start) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + Stream_Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign Checksum = sum_q;
`endif

    assign Busy              = (state_q == READ) || (state_q == DRAIN);
    assign Done              = (state_q == DONE);
    assign Avalon_ChipEnable = 1'b1;
    assign Avalon_Address    = addr_q;
    assign Avalon_ByteEnable = 2'b11;
    assign Avalon_Read       = read_q;
    assign Avalon_Write      = 1'b0;
    assign Avalon_WriteData  = '0;
    assign Stream_Data       = mem_q[rptr_q];
    assign Stream_Valid      = (cnt_q != '0);

endmodule

// File: tb/tb_mm_block_reader.sv
// tb_mm_block_reader: randomized self-checking bench for mm_block_reader.
// Memory model word at address a is a[15:0] ^ salt.
module tb_mm_block_reader;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int LW = 13;
    localparam int FD = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic [AW-1:0] Base_Address = '0;
    logic [LW-1:0] Length = '0;
    logic          Busy, Done, Avalon_ChipEnable, Avalon_Read, Avalon_Write;
    logic [AW-1:0] Avalon_Address;
    logic [1:0]    Avalon_ByteEnable;
    logic [DW-1:0] Avalon_WriteData;
    logic          Avalon_WaitRequest = 1'b0;
    logic [DW-1:0] Avalon_ReadData = '0;
    logic          Avalon_ReadDataValid = 1'b0;
    logic [DW-1:0] Stream_Data;
    logic          Stream_Valid;
    logic          Stream_Ready = 1'b0;
`ifdef MM_READ_CHECKSUM_EN
    logic [DW-1:0] Checksum;
`endif

    mm_block_reader dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Base_Address(Base_Address), .Length(Length),
        .Busy(Busy), .Done(Done),
        .Avalon_ChipEnable(Avalon_ChipEnable),
        .Avalon_Address(Avalon_Address),
        .Avalon_ByteEnable(Avalon_ByteEnable),
        .Avalon_Read(Avalon_Read), .Avalon_Write(Avalon_Write),
        .Avalon_WriteData(Avalon_WriteData),
        .Avalon_WaitRequest(Avalon_WaitRequest),
        .Avalon_ReadData(Avalon_ReadData),
        .Avalon_ReadDataValid(Avalon_ReadDataValid),
        .Stream_Data(Stream_Data), .Stream_Valid(Stream_Valid),
        .Stream_Ready(Stream_Ready)
`ifdef MM_READ_CHECKSUM_EN
        , .Checksum(Checksum)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int ready_mode = 0;
    int stall_mode = 0;
    int stall_left = 0;
    bit stalled_once = 0;
    int n_acc, n_pop, n_ret, done_cnt, stall_seen, first_acc, last_acc;
    logic [AW-1:0] stall_addr;
    logic [DW-1:0] salt = '0;
    logic [DW-1:0] exp_sum;
    logic [AW-1:0] got_addr[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] got_data[$];
    logic [DW-1:0] exp_data[$];
    int            resp_due[$];
    logic [DW-1:0] resp_dat[$];
    bit            prev_rw = 0;
    logic [AW-1:0] prev_addr;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[DW-1:0] ^ salt;
    endfunction

    // One bus cycle: observe outputs, then drive slave and consumer inputs.
    task automatic do_cycle();
        @(negedge Clk);
        cyc++;
        Start = 1'b0;
        if (prev_rw) begin
            checks++;
            if (Avalon_Read !== 1'b1 || Avalon_Address !== prev_addr) begin
                errors++;
                $display("FAIL stall_hold read=%b addr=%h required read=1 addr=%h",
                         Avalon_Read, Avalon_Address, prev_addr);
            end
        end
        if (Done === 1'b1) begin
            done_cnt++;
            checks++;
            if (Busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done busy=%b required 0", Busy);
            end
        end
        case (ready_mode)
            0:       Stream_Ready = 1'b1;
            1:       Stream_Ready = 1'($urandom_range(0, 1));
            default: Stream_Ready = 1'b0;
        endcase
        if (Stream_Valid === 1'b1 && Stream_Ready) begin
            got_data.push_back(Stream_Data);
            n_pop++;
        end
        if (stall_mode == 2 && n_acc == 1 && !stalled_once &&
            Avalon_Read === 1'b1) begin
            stall_left = 3;
            stalled_once = 1;
        end
        if (stall_mode == 1) begin
            Avalon_WaitRequest = ($urandom_range(0, 3) == 0);
        end else if (stall_mode == 3) begin
            Avalon_WaitRequest = (n_acc >= 7);
        end else if (stall_left > 0) begin
            Avalon_WaitRequest = 1'b1;
            stall_left--;
        end else begin
            Avalon_WaitRequest = 1'b0;
        end
        if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
            Avalon_ReadDataValid = 1'b1;
            Avalon_ReadData = resp_dat.pop_front();
            void'(resp_due.pop_front());
            n_ret++;
        end else begin
            Avalon_ReadDataValid = 1'b0;
            Avalon_ReadData = DW'($urandom);
        end
        prev_rw = 0;
        if (Avalon_Read === 1'b1 && Avalon_WaitRequest) begin
            prev_rw = 1;
            prev_addr = Avalon_Address;
            stall_seen++;
            stall_addr = Avalon_Address;
        end
        if (Avalon_Read === 1'b1 && !Avalon_WaitRequest) begin
            got_addr.push_back(Avalon_Address);
            resp_due.push_back(cyc + lat);
            resp_dat.push_back(mem_word(Avalon_Address));
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
        end
        checks++;
        if (n_acc - n_pop > FD) begin
            errors++;
            $display("FAIL credit outstanding=%0d required <= %0d",
                     n_acc - n_pop, FD);
        end
    endtask

    task automatic start_block(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        exp_addr.delete();
        exp_data.delete();
        got_addr.delete();
        got_data.delete();
        exp_sum = '0;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
            exp_sum = exp_sum + mem_word(a);
        end
        n_acc = 0; n_pop = 0; n_ret = 0; done_cnt = 0; stall_seen = 0;
        stalled_once = 0;
        do_cycle();
        Start = 1'b1;
        Base_Address = base;
        Length = LW'(len);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            do_cycle();
            k++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout done=0 after %0d cycles required 1",
                     name, budget);
        end
        repeat (3) do_cycle();
    endtask

    task automatic check_block(input string name);
        int bad;
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL %s_nreads got %0d required %0d", name,
                     got_addr.size(), exp_addr.size());
        end
        bad = -1;
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            if (bad < 0 && got_addr[i] !== exp_addr[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_addr[%0d] got %h required %h", name, bad,
                     got_addr[bad], exp_addr[bad]);
        end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL %s_nwords got %0d required %0d", name,
                     got_data.size(), exp_data.size());
        end
        bad = -1;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
            if (bad < 0 && got_data[i] !== exp_data[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data[%0d] got %h required %h", name, bad,
                     got_data[bad], exp_data[bad]);
        end
        checks++;
        if (done_cnt != 1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done pulses=%0d busy=%b required 1 and 0",
                     name, done_cnt, Busy);
        end
`ifdef MM_READ_CHECKSUM_EN
        checks++;
        if (Checksum !== exp_sum) begin
            errors++;
            $display("FAIL %s_checksum got %h required %h", name,
                     Checksum, exp_sum);
        end
`endif
    endtask

    task automatic test_reset();
        repeat (3) do_cycle();
        checks++;
        if (Busy !== 0 || Done !== 0 || Avalon_Read !== 0 ||
            Avalon_Address !== '0 || Stream_Valid !== 0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b rd=%b addr=%h sv=%b required all 0",
                     Busy, Done, Avalon_Read, Avalon_Address, Stream_Valid);
        end
        Reset = 1'b1;
        repeat (2) do_cycle();
        checks++;
        if (Avalon_ChipEnable !== 1'b1 || Avalon_ByteEnable !== 2'b11 ||
            Avalon_Write !== 1'b0 || Avalon_WriteData !== '0) begin
            errors++;
            $display("FAIL tied_outputs ce=%b be=%b wr=%b wd=%h required 1 11 0 0",
                     Avalon_ChipEnable, Avalon_ByteEnable, Avalon_Write,
                     Avalon_WriteData);
        end
        checks++;
        if (Busy !== 0 || Avalon_Read !== 0 || Stream_Valid !== 0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b rd=%b sv=%b required 0 0 0",
                     Busy, Avalon_Read, Stream_Valid);
        end
    endtask

    task automatic test_zero_wait();
        salt = '0; lat = 1; ready_mode = 0; stall_mode = 0;
        start_block(25'h100, 4);
        wait_done(200, "zero_wait");
        check_block("zero_wait");
        checks++;
        if (last_acc - first_acc != 3) begin
            errors++;
            $display("FAIL back_to_back span=%0d required 3", last_acc - first_acc);
        end
`ifdef MM_READ_CHECKSUM_EN
        repeat (4) do_cycle();
        checks++;
        if (Checksum !== 16'h0406) begin
            errors++;
            $display("FAIL checksum_hold got %h required 0406", Checksum);
        end
`endif
    endtask

    task automatic test_stall();
        salt = '0; lat = 1; ready_mode = 0; stall_mode = 2;
        start_block(25'h100, 4);
        wait_done(200, "stall");
        check_block("stall");
        checks++;
        if (stall_seen != 3 || stall_addr !== 25'h101) begin
            errors++;
            $display("FAIL stall_cycles got %0d at %h required 3 at 0000101",
                     stall_seen, stall_addr);
        end
        stall_mode = 0;
    endtask

    task automatic test_backpressure();
        salt = DW'($urandom); lat = 2; ready_mode = 2; stall_mode = 0;
        start_block(AW'($urandom), 40);
        repeat (40) do_cycle();
        checks++;
        if (n_acc != FD || Avalon_Read !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_reads got %0d rd=%b required %0d rd=0",
                     n_acc, Avalon_Read, FD);
        end
        checks++;
        if (Stream_Valid !== 1'b1 || Stream_Data !== exp_data[0]) begin
            errors++;
            $display("FAIL backpressure_head sv=%b data=%h required 1 %h",
                     Stream_Valid, Stream_Data, exp_data[0]);
        end
        ready_mode = 0;
        wait_done(400, "backpressure");
        check_block("backpressure");
    endtask

    task automatic test_zero_length();
        salt = '0; lat = 1; ready_mode = 0; stall_mode = 0;
        start_block(25'h55, 0);
        do_cycle();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || n_acc != 0) begin
            errors++;
            $display("FAIL zero_len_done done=%b busy=%b reads=%0d required 1 0 0",
                     Done, Busy, n_acc);
        end
        do_cycle();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || n_acc != 0) begin
            errors++;
            $display("FAIL zero_len_after done=%b busy=%b reads=%0d required 0 0 0",
                     Done, Busy, n_acc);
        end
        start_block(25'h200, 8);
        repeat (3) do_cycle();
        Start = 1'b1;
        Base_Address = 25'h300;
        Length = LW'(2);
        wait_done(200, "start_ignored");
        check_block("start_ignored");
    endtask

    task automatic test_wrap();
        salt = 16'h3c5a; lat = 1; ready_mode = 0; stall_mode = 0;
        start_block(25'h1FFFFFE, 4);
        wait_done(200, "wrap");
        check_block("wrap");
    endtask

    task automatic test_reset_mid();
        int k = 0;
        salt = '0; lat = 3; ready_mode = 2; stall_mode = 3;
        start_block(25'h400, 20);
        while (n_ret < 5 && k < 60) begin
            do_cycle();
            k++;
        end
        @(posedge Clk);
        #2;
        checks++;
        if (n_acc - n_ret != 2 || Stream_Valid !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset inflight=%0d sv=%b busy=%b required 2 1 1",
                     n_acc - n_ret, Stream_Valid, Busy);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 0 || Done !== 0 || Avalon_Read !== 0 ||
            Avalon_Address !== '0 || Stream_Valid !== 0) begin
            errors++;
            $display("FAIL mid_reset busy=%b done=%b rd=%b addr=%h sv=%b required all 0",
                     Busy, Done, Avalon_Read, Avalon_Address, Stream_Valid);
        end
        prev_rw = 0;
        stall_mode = 0;
        ready_mode = 0;
        do_cycle();
        Reset = 1'b1;
        repeat (6) do_cycle();
        checks++;
        if (Stream_Valid !== 1'b0 || Busy !== 1'b0 || resp_due.size() != 0) begin
            errors++;
            $display("FAIL stale_dropped sv=%b busy=%b queued=%0d required 0 0 0",
                     Stream_Valid, Busy, resp_due.size());
        end
        lat = 1;
        start_block(25'h777, 2);
        wait_done(200, "after_reset");
        check_block("after_reset");
    endtask

    task automatic test_random();
        for (int b = 0; b < 10; b++) begin
            salt = DW'($urandom);
            lat = $urandom_range(1, 3);
            ready_mode = 1;
            stall_mode = 1;
            start_block(AW'($urandom), $urandom_range(1, 50));
            wait_done(3000, "random");
            check_block("random");
        end
        stall_mode = 0;
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_backpressure();
        test_zero_length();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
